// File: rtl/uc_gera_frame_multicanal_pkg.sv
// Shared definitions for the multi-class frame composer: state codes, idle select and class ids.
package uc_gera_frame_multicanal_pkg;

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        ESPERA     = 4'd1,
        LIMPA      = 4'd2,
        ESPERA_MEM = 4'd3,
        VERIFICA   = 4'd4,
        SALVA      = 4'd5,
        AVANCA     = 4'd6,
        SINALIZA   = 4'd7
    } estado_t;

    localparam logic [3:0]  DB_INVALIDO = 4'hF;
    // Wide all-ones; users slice it down to their select width.
    localparam logic [31:0] SEL_IDLE    = '1;

    localparam int unsigned CLASSE_ASTEROIDE = 0;
    localparam int unsigned CLASSE_TIRO      = 1;
    localparam int unsigned CLASSE_NAVE      = 2;

    function automatic int unsigned largura_classe(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uc_gera_frame_multicanal_if.sv
// Control/status bundle between the frame composer and its host (object memory, frame memory, mux).
interface uc_gera_frame_multicanal_if #(
    parameter int N_CLASSES = 3,
    parameter int IDX_W     = 4,
    parameter int SEL_W     = 2
);
    import uc_gera_frame_multicanal_pkg::*;

    localparam int CL_W = largura_classe(N_CLASSES);

    logic                       gera_frame;
    logic [N_CLASSES*IDX_W-1:0] n_objetos;
    logic                       loaded;
    logic [CL_W-1:0]            classe;
    logic [IDX_W-1:0]           indice;
    logic                       clear_mem_frame;
    logic                       enable_mem_frame;
    logic [SEL_W-1:0]           select_mux_gera_frame;
    logic                       ocupado;
    logic                       fim_gera_frame;
    logic [3:0]                 db_estado;

    modport master (
        output gera_frame, n_objetos, loaded,
        input  classe, indice, clear_mem_frame, enable_mem_frame,
               select_mux_gera_frame, ocupado, fim_gera_frame, db_estado
    );

    modport slave (
        input  gera_frame, n_objetos, loaded,
        output classe, indice, clear_mem_frame, enable_mem_frame,
               select_mux_gera_frame, ocupado, fim_gera_frame, db_estado
    );

endinterface

// File: rtl/uc_gera_frame_multicanal_contador_varredura.sv
// Class/index scan counter: latches per-class counts on zera, steps on avanca, flags end of class/scan.
module contador_varredura #(
    parameter int N_CLASSES = 3,
    parameter int IDX_W     = 4,
    parameter int CL_W      = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       zera,
    input  logic                       avanca,
    input  logic [N_CLASSES*IDX_W-1:0] n_objetos,
    output logic [CL_W-1:0]            classe,
    output logic [IDX_W-1:0]           indice,
    output logic                       classe_vazia,
    output logic                       ultima_classe,
    output logic                       fim_classe,
    output logic                       fim_varredura
);

    logic [IDX_W-1:0] n_lat [N_CLASSES];
    logic [IDX_W-1:0] n_atual;

    always_comb begin
        n_atual       = n_lat[classe];
        classe_vazia  = (n_atual == '0);
        ultima_classe = (classe == CL_W'(N_CLASSES - 1));
        // Empty class short-circuits so n-1 never underflows into a real index.
        fim_classe    = classe_vazia || (indice == n_atual - 1'b1);
        fim_varredura = fim_classe && ultima_classe;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            classe <= '0;
            indice <= '0;
            for (int unsigned k = 0; k < N_CLASSES; k++) begin
                n_lat[k] <= '0;
            end
        end else if (zera) begin
            classe <= '0;
            indice <= '0;
            for (int unsigned k = 0; k < N_CLASSES; k++) begin
                n_lat[k] <= n_objetos[k*IDX_W +: IDX_W];
            end
        end else if (avanca) begin
            if (!fim_classe) begin
                indice <= indice + 1'b1;
            end else if (!ultima_classe) begin
                classe <= classe + 1'b1;
                indice <= '0;
            end
        end
    end

endmodule

// File: rtl/uc_gera_frame_multicanal.sv
// Frame composition control unit: clears the frame memory, then scans every object of every class
// and writes the active ones through the mux/enable pair.
module uc_gera_frame_multicanal
    import uc_gera_frame_multicanal_pkg::*;
#(
    parameter int N_CLASSES   = 3,
    parameter int IDX_W       = 4,
    parameter int SEL_W       = 2,
    parameter int MEM_WAIT    = 1,
    parameter int ALWAYS_LAST = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    uc_gera_frame_multicanal_if.slave    bus
);

    localparam int CL_W   = largura_classe(N_CLASSES);
    localparam int WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_FIM = (MEM_WAIT > 0) ? WAIT_W'(MEM_WAIT - 1) : '0;
    localparam estado_t APOS_INDICE = (MEM_WAIT > 0) ? ESPERA_MEM : VERIFICA;

    estado_t           estado, prox;
    logic [WAIT_W-1:0] cnt_espera;
    logic              zera, avanca;
    logic              classe_vazia, ultima_classe, fim_classe, fim_varredura;

    contador_varredura #(
        .N_CLASSES (N_CLASSES),
        .IDX_W     (IDX_W),
        .CL_W      (CL_W)
    ) u_contador (
        .clock         (clock),
        .reset         (reset),
        .zera          (zera),
        .avanca        (avanca),
        .n_objetos     (bus.n_objetos),
        .classe        (bus.classe),
        .indice        (bus.indice),
        .classe_vazia  (classe_vazia),
        .ultima_classe (ultima_classe),
        .fim_classe    (fim_classe),
        .fim_varredura (fim_varredura)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_espera <= '0;
        end else if (estado == ESPERA_MEM && cnt_espera != WAIT_FIM) begin
            cnt_espera <= cnt_espera + 1'b1;
        end else begin
            cnt_espera <= '0;
        end
    end

    always_comb begin
        prox   = estado;
        zera   = 1'b0;
        avanca = 1'b0;
        case (estado)
            INICIAL:    prox = ESPERA;
            ESPERA:     if (bus.gera_frame) prox = LIMPA;
            LIMPA: begin
                zera = 1'b1;
                prox = APOS_INDICE;
            end
            ESPERA_MEM: if (cnt_espera == WAIT_FIM) prox = VERIFICA;
            VERIFICA: begin
                if (classe_vazia) begin
                    prox = AVANCA;
                end else if (bus.loaded || (ALWAYS_LAST != 0 && ultima_classe)) begin
                    prox = SALVA;
                end else begin
                    prox = AVANCA;
                end
            end
            SALVA:      prox = AVANCA;
            AVANCA: begin
                avanca = 1'b1;
                prox   = fim_varredura ? SINALIZA : APOS_INDICE;
            end
            SINALIZA:   prox = ESPERA;
            default:    prox = INICIAL;
        endcase
    end

    always_comb begin
        bus.clear_mem_frame       = (estado == LIMPA);
        bus.enable_mem_frame      = (estado == SALVA);
        bus.fim_gera_frame        = (estado == SINALIZA);
        bus.ocupado               = (estado != INICIAL) && (estado != ESPERA);
        bus.select_mux_gera_frame = SEL_IDLE[SEL_W-1:0];
        if (estado == SALVA) begin
            bus.select_mux_gera_frame = SEL_W'(bus.classe);
        end
        bus.db_estado = (estado <= SINALIZA) ? estado : DB_INVALIDO;
    end

    logic unused_fim_classe;
    assign unused_fim_classe = fim_classe;

endmodule

// File: tb/tb_uc_gera_frame_multicanal.sv
// Scoreboard bench: two composers (different wait / always-last settings) share stimulus; a reference
// model derives the expected write list and frame length from the per-class counts and loaded map.
module tb_uc_gera_frame_multicanal;

    localparam int N = 3;
    localparam int IW = 4;
    localparam int SW = 2;
    localparam int WAIT_D [2] = '{1, 3};
    localparam int LAST_D [2] = '{1, 0};

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    uc_gera_frame_multicanal_if #(.N_CLASSES(N), .IDX_W(IW), .SEL_W(SW)) bus_a ();
    uc_gera_frame_multicanal_if #(.N_CLASSES(N), .IDX_W(IW), .SEL_W(SW)) bus_b ();

    uc_gera_frame_multicanal #(
        .N_CLASSES(N), .IDX_W(IW), .SEL_W(SW), .MEM_WAIT(1), .ALWAYS_LAST(1)
    ) dut_a (.clock(clock), .reset(reset), .bus(bus_a));

    uc_gera_frame_multicanal #(
        .N_CLASSES(N), .IDX_W(IW), .SEL_W(SW), .MEM_WAIT(3), .ALWAYS_LAST(0)
    ) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    logic          gera;
    logic [N*IW-1:0] nobj;
    logic [15:0]   mapa [4];

    assign bus_a.gera_frame = gera;
    assign bus_b.gera_frame = gera;
    assign bus_a.n_objetos  = nobj;
    assign bus_b.n_objetos  = nobj;
    assign bus_a.loaded     = mapa[bus_a.classe][bus_a.indice];
    assign bus_b.loaded     = mapa[bus_b.classe][bus_b.indice];

    logic       en [2], clr [2], fim [2], ocp [2];
    logic [1:0] cls [2], sel [2];
    logic [3:0] idx [2], db [2];

    assign en[0] = bus_a.enable_mem_frame;      assign en[1] = bus_b.enable_mem_frame;
    assign clr[0] = bus_a.clear_mem_frame;      assign clr[1] = bus_b.clear_mem_frame;
    assign fim[0] = bus_a.fim_gera_frame;       assign fim[1] = bus_b.fim_gera_frame;
    assign ocp[0] = bus_a.ocupado;              assign ocp[1] = bus_b.ocupado;
    assign cls[0] = bus_a.classe;               assign cls[1] = bus_b.classe;
    assign sel[0] = bus_a.select_mux_gera_frame; assign sel[1] = bus_b.select_mux_gera_frame;
    assign idx[0] = bus_a.indice;               assign idx[1] = bus_b.indice;
    assign db[0] = bus_a.db_estado;             assign db[1] = bus_b.db_estado;

    int n_checks = 0;
    int n_pass = 0;
    int q_wr [2][$];
    int q_len [2][$];
    int clr_cnt [2];
    int starts = 0;

    function void check(input string nome, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, act, exp, $time);
    endfunction

    // Reference model: expected writes in scan order and frame length in cycles (LIMPA = 1 .. SINALIZA).
    task automatic push_frame();
        for (int d = 0; d < 2; d++) begin
            int steps = 0;
            int writes = 0;
            for (int k = 0; k < N; k++) begin
                int n = int'(nobj[k*IW +: IW]);
                steps += (n == 0) ? 1 : n;
                for (int i = 0; i < n; i++) begin
                    if (mapa[k][i] || (LAST_D[d] != 0 && k == N - 1)) begin
                        q_wr[d].push_back(k * 16 + i);
                        writes++;
                    end
                end
            end
            q_len[d].push_back(2 + steps * (WAIT_D[d] + 2) + writes);
        end
        starts++;
    endtask

    task automatic mon(input int d);
        bit ativo = 0;
        int cyc = 0;
        int e;
        forever begin
            @(negedge clock);
            if (reset) begin
                ativo = 0;
                continue;
            end
            if (ativo) cyc++;
            if (clr[d]) begin
                clr_cnt[d]++;
                ativo = 1;
                cyc = 1;
            end
            if (en[d]) begin
                check($sformatf("dut%0d write_expected", d), int'(q_wr[d].size() > 0), 1);
                if (q_wr[d].size() > 0) begin
                    e = q_wr[d].pop_front();
                    check($sformatf("dut%0d wr_classe", d), int'(cls[d]), e / 16);
                    check($sformatf("dut%0d wr_indice", d), int'(idx[d]), e % 16);
                    check($sformatf("dut%0d wr_select", d), int'(sel[d]), e / 16);
                end
            end
            if (fim[d]) begin
                check($sformatf("dut%0d fim_expected", d), int'(q_len[d].size() > 0), 1);
                if (q_len[d].size() > 0) begin
                    check($sformatf("dut%0d frame_len", d), cyc, q_len[d].pop_front());
                    check($sformatf("dut%0d writes_left", d), q_wr[d].size(), 0);
                end
                ativo = 0;
            end
        end
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
        join_none
    end

    task automatic chk_reset(input int d);
        check($sformatf("dut%0d rst_db", d), int'(db[d]), 0);
        check($sformatf("dut%0d rst_ocupado", d), int'(ocp[d]), 0);
        check($sformatf("dut%0d rst_enable", d), int'(en[d]), 0);
        check($sformatf("dut%0d rst_clear", d), int'(clr[d]), 0);
        check($sformatf("dut%0d rst_fim", d), int'(fim[d]), 0);
        check($sformatf("dut%0d rst_select", d), int'(sel[d]), 3);
        check($sformatf("dut%0d rst_classe", d), int'(cls[d]), 0);
        check($sformatf("dut%0d rst_indice", d), int'(idx[d]), 0);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (db[0] == 4'd1 && db[1] == 4'd1) break;
        end
        // A request seen while busy must not leave a pending restart behind.
        repeat (3) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d idle_espera", d), int'(db[d]), 1);
            check($sformatf("dut%0d idle_ocupado", d), int'(ocp[d]), 0);
            check($sformatf("dut%0d clear_count", d), clr_cnt[d], starts);
            check($sformatf("dut%0d pending_frames", d), q_len[d].size(), 0);
        end
    endtask

    task automatic run_frame(input logic [N*IW-1:0] n, input logic [15:0] m0, input logic [15:0] m1,
                             input logic [15:0] m2, input bit hold, input bit mexe);
        bit visto = 0;
        @(negedge clock);
        nobj = n;
        mapa[0] = m0; mapa[1] = m1; mapa[2] = m2; mapa[3] = '0;
        push_frame();
        gera = 1'b1;
        @(posedge clock); #1;
        if (!hold) gera = 1'b0;
        @(posedge clock); #1;
        if (mexe) nobj = N*IW'($urandom);
        if (hold) begin
            for (int c = 0; c < 1000; c++) begin
                @(negedge clock);
                if (fim[0]) begin
                    visto = 1;
                    break;
                end
            end
            gera = 1'b0;
            check("hold_fim_seen", int'(visto), 1);
        end else begin
            repeat (3) @(negedge clock);
            gera = 1'b1;
            @(negedge clock);
            gera = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit achou = 0;
        gera = 1'b0;
        nobj = '0;
        for (int k = 0; k < 4; k++) mapa[k] = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk_reset(0);
        chk_reset(1);
        @(posedge clock); #2 reset = 1'b0;
        repeat (2) @(negedge clock);

        // counts {2,1,1}, nothing loaded: only the forced last-class write on dut0
        run_frame({4'd1, 4'd1, 4'd2}, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        run_frame({4'd1, 4'd2, 4'd3}, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1);
        run_frame({4'd1, 4'd0, 4'd0}, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        run_frame({4'd15, 4'd0, 4'd15}, 16'hFFFF, 16'h0000, 16'h5A5A, 0, 1);
        run_frame({4'd3, 4'd4, 4'd2}, 16'h000A, 16'h0005, 16'h0000, 1, 1);

        // reset while dut0 sits in SALVA
        @(negedge clock);
        nobj = {4'd1, 4'd2, 4'd3};
        for (int k = 0; k < 3; k++) mapa[k] = '1;
        push_frame();
        gera = 1'b1;
        @(posedge clock); #1 gera = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (en[0]) begin
                achou = 1;
                break;
            end
        end
        check("salva_reached", int'(achou), 1);
        #1 reset = 1'b1;
        #1;
        chk_reset(0);
        chk_reset(1);
        for (int d = 0; d < 2; d++) begin
            q_wr[d].delete();
            q_len[d].delete();
            clr_cnt[d] = 0;
        end
        starts = 0;
        @(negedge clock);
        @(posedge clock); #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        run_frame({4'd1, 4'd1, 4'd2}, 16'h0001, 16'h0000, 16'h0000, 0, 0);

        for (int f = 0; f < 14; f++) begin
            logic [N*IW-1:0] n;
            for (int k = 0; k < N; k++) begin
                n[k*IW +: IW] = ($urandom_range(0, 7) == 0) ? 4'd15 : IW'($urandom_range(0, 5));
            end
            run_frame(n, 16'($urandom), 16'($urandom), 16'($urandom), (f % 5) == 4, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
